// File: rtl/frame_decode_ext_if.sv
// PCD bit-sequence encoding plus the bundle that carries sequence_decode symbols
// into frame_decode_ext and its decoded frame results back out.
package frame_decode_ext_pkg;
  typedef enum logic [1:0] {
    SEQ_X     = 2'd0,
    SEQ_Y     = 2'd1,
    SEQ_Z     = 2'd2,
    SEQ_ERROR = 2'd3
  } pcd_bit_seq_t;
endpackage

interface frame_decode_ext_if #(
  parameter int BC_W = 7
);
  import frame_decode_ext_pkg::*;

  pcd_bit_seq_t    sd_seq;
  logic            sd_seq_valid;
  logic            soc;
  logic            eoc;
  logic [7:0]      data;
  logic [2:0]      data_bits;
  logic            data_valid;
  logic [BC_W-1:0] byte_count;
  logic            crc_ok;
  logic            short_frame;
  logic            sequence_error;
  logic            parity_error;
  logic            length_error;

  modport master (
    output sd_seq, sd_seq_valid,
    input  soc, eoc, data, data_bits, data_valid, byte_count,
           crc_ok, short_frame, sequence_error, parity_error, length_error
  );

  modport slave (
    input  sd_seq, sd_seq_valid,
    output soc, eoc, data, data_bits, data_valid, byte_count,
           crc_ok, short_frame, sequence_error, parity_error, length_error
  );
endinterface

// File: rtl/frame_decode_ext.sv
// PCD frame decoder: turns X/Y/Z symbols into SOC/EOC, bytes and error pulses,
// with odd-parity checking, a byte limit, running CRC_A and short-frame detection.
module frame_decode_ext
  import frame_decode_ext_pkg::*;
#(
  parameter int MAX_BYTES    = 64,
  parameter bit PARITY_CHECK = 1'b1,
  parameter bit CRC_CHECK    = 1'b1,
  parameter int BC_W         = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_decode_ext_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RX   = 1'b1
  } state_t;

  localparam logic [BC_W-1:0] MAX_BC   = BC_W'(MAX_BYTES);
  localparam logic [BC_W-1:0] BC_ONE   = BC_W'(1'b1);
  localparam logic [15:0]     CRC_INIT = 16'h6363;

  // One bit of the reflected CRC_A (poly 0x8408) shift register.
  function automatic logic [15:0] crc_a_bit(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[0] ^ b;
    return (crc >> 1) ^ (fb ? 16'h8408 : 16'h0000);
  endfunction

  state_t          state_q, state_d;
  pcd_bit_seq_t    last_seq_q, last_seq_d;
  logic [7:0]      data_q, data_d;
  logic [2:0]      data_bits_q, data_bits_d;
  logic [BC_W-1:0] byte_count_q, byte_count_d;
  logic [15:0]     crc_q, crc_d;
  logic            crc_ok_q, crc_ok_d;
  logic            short_frame_q, short_frame_d;
  logic            err_q, err_d;
  logic            par_pend_q, par_pend_d;
  logic            exp_par_q, exp_par_d;
  logic            bits_seen_q, bits_seen_d;
  logic            soc_q, soc_d;
  logic            eoc_q, eoc_d;
  logic            data_valid_q, data_valid_d;
  logic            seq_err_q, seq_err_d;
  logic            par_err_q, par_err_d;
  logic            len_err_q, len_err_d;

  logic            bit_s;
  logic            frame_err_s;
  logic            eoc_hit_s;

  assign bit_s     = (last_seq_q == SEQ_X);
  // A Y following a logic-0 symbol closes the frame; that trailing 0 is not data.
  assign eoc_hit_s = (bus.sd_seq == SEQ_Y) &&
                     ((last_seq_q == SEQ_Y) || (last_seq_q == SEQ_Z));

  // Next-state and output decode, evaluated against the previous symbol.
  always_comb begin
    state_d       = state_q;
    last_seq_d    = last_seq_q;
    data_d        = data_q;
    data_bits_d   = data_bits_q;
    byte_count_d  = byte_count_q;
    crc_d         = crc_q;
    crc_ok_d      = crc_ok_q;
    short_frame_d = short_frame_q;
    err_d         = err_q;
    par_pend_d    = par_pend_q;
    exp_par_d     = exp_par_q;
    bits_seen_d   = bits_seen_q;
    soc_d         = 1'b0;
    eoc_d         = 1'b0;
    data_valid_d  = 1'b0;
    seq_err_d     = 1'b0;
    par_err_d     = 1'b0;
    len_err_d     = 1'b0;
    frame_err_s   = err_q || par_pend_q || !bits_seen_q;

    if (bus.sd_seq_valid) begin
      last_seq_d = bus.sd_seq;
      case (state_q)
        ST_IDLE: begin
          if (last_seq_q == SEQ_Z) begin
            soc_d         = 1'b1;
            state_d       = ST_RX;
            data_bits_d   = 3'd0;
            byte_count_d  = '0;
            crc_ok_d      = 1'b0;
            short_frame_d = 1'b0;
            err_d         = 1'b0;
            par_pend_d    = 1'b0;
            exp_par_d     = 1'b1;
            crc_d         = CRC_INIT;
            bits_seen_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RX: begin
          if (eoc_hit_s) begin
            eoc_d         = 1'b1;
            state_d       = ST_IDLE;
            par_err_d     = par_pend_q;
            seq_err_d     = !bits_seen_q && !err_q;
            data_valid_d  = !err_q && !par_pend_q && (data_bits_q != 3'd0);
            short_frame_d = !frame_err_s && (byte_count_q == '0) && (data_bits_q == 3'd7);
            crc_ok_d      = CRC_CHECK && !frame_err_s && (data_bits_q == 3'd0) &&
                            (32'(byte_count_q) >= 32'd3) && (crc_q == 16'h0000);
          end else if (err_q) begin
            state_d = ST_RX;
          end else if (last_seq_q == SEQ_ERROR) begin
            seq_err_d  = 1'b1;
            err_d      = 1'b1;
            par_pend_d = 1'b0;
          end else if (par_pend_q) begin
            par_pend_d = 1'b0;
            if (PARITY_CHECK && (bit_s != exp_par_q)) begin
              par_err_d = 1'b1;
              err_d     = 1'b1;
            end else if (byte_count_q == MAX_BC) begin
              len_err_d = 1'b1;
              err_d     = 1'b1;
            end else begin
              data_valid_d = 1'b1;
              data_bits_d  = 3'd0;
              byte_count_d = byte_count_q + BC_ONE;
              exp_par_d    = 1'b1;
            end
          end else begin
            data_d[data_bits_q] = bit_s;
            data_bits_d         = data_bits_q + 3'd1;
            exp_par_d           = exp_par_q ^ bit_s;
            par_pend_d          = (data_bits_q == 3'd7);
            crc_d               = crc_a_bit(crc_q, bit_s);
            bits_seen_d         = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      last_seq_d = last_seq_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_seq_q    <= SEQ_Y;
      data_q        <= 8'd0;
      data_bits_q   <= 3'd0;
      byte_count_q  <= '0;
      crc_q         <= CRC_INIT;
      crc_ok_q      <= 1'b0;
      short_frame_q <= 1'b0;
      err_q         <= 1'b0;
      par_pend_q    <= 1'b0;
      exp_par_q     <= 1'b1;
      bits_seen_q   <= 1'b0;
      soc_q         <= 1'b0;
      eoc_q         <= 1'b0;
      data_valid_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      par_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_seq_q    <= last_seq_d;
      data_q        <= data_d;
      data_bits_q   <= data_bits_d;
      byte_count_q  <= byte_count_d;
      crc_q         <= crc_d;
      crc_ok_q      <= crc_ok_d;
      short_frame_q <= short_frame_d;
      err_q         <= err_d;
      par_pend_q    <= par_pend_d;
      exp_par_q     <= exp_par_d;
      bits_seen_q   <= bits_seen_d;
      soc_q         <= soc_d;
      eoc_q         <= eoc_d;
      data_valid_q  <= data_valid_d;
      seq_err_q     <= seq_err_d;
      par_err_q     <= par_err_d;
      len_err_q     <= len_err_d;
    end
  end

  assign bus.soc            = soc_q;
  assign bus.eoc            = eoc_q;
  assign bus.data           = data_q;
  assign bus.data_bits      = data_bits_q;
  assign bus.data_valid     = data_valid_q;
  assign bus.byte_count     = byte_count_q;
  assign bus.crc_ok         = crc_ok_q;
  assign bus.short_frame    = short_frame_q;
  assign bus.sequence_error = seq_err_q;
  assign bus.parity_error   = par_err_q;
  assign bus.length_error   = len_err_q;

endmodule

// File: tb/tb_frame_decode_ext.sv
// Directed bench: three decoder variants (default, no parity check, MAX_BYTES=2)
// share one symbol stream; per-frame pulse counts and captured bytes are checked.
module tb_frame_decode_ext;
  import frame_decode_ext_pkg::*;

  localparam int P_SOC = 5, P_EOC = 4, P_DV = 3, P_SEQ = 2, P_PAR = 1, P_LEN = 0;
  localparam int D_DEF = 0, D_NP = 1, D_MX = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  pcd_bit_seq_t seq_s = SEQ_Y;
  logic         vld_s = 1'b0;
  logic         prev_one = 1'b0;
  int           n_err = 0;
  int           n_chk = 0;

  always #5 clk = ~clk;

  frame_decode_ext_if #(.BC_W(7)) if_def ();
  frame_decode_ext_if #(.BC_W(7)) if_np ();
  frame_decode_ext_if #(.BC_W(2)) if_mx ();

  assign if_def.sd_seq = seq_s;  assign if_def.sd_seq_valid = vld_s;
  assign if_np.sd_seq  = seq_s;  assign if_np.sd_seq_valid  = vld_s;
  assign if_mx.sd_seq  = seq_s;  assign if_mx.sd_seq_valid  = vld_s;

  frame_decode_ext #(.MAX_BYTES(64), .PARITY_CHECK(1'b1), .CRC_CHECK(1'b1), .BC_W(7))
    u_def (.clk(clk), .rst_n(rst_n), .bus(if_def));
  frame_decode_ext #(.MAX_BYTES(64), .PARITY_CHECK(1'b0), .CRC_CHECK(1'b1), .BC_W(7))
    u_np (.clk(clk), .rst_n(rst_n), .bus(if_np));
  frame_decode_ext #(.MAX_BYTES(2), .PARITY_CHECK(1'b1), .CRC_CHECK(1'b1), .BC_W(2))
    u_mx (.clk(clk), .rst_n(rst_n), .bus(if_mx));

  logic [5:0]  pl   [3];
  logic [10:0] dvw  [3];
  logic [6:0]  bcv  [3];
  logic [1:0]  lvl  [3];

  assign pl[0] = {if_def.soc, if_def.eoc, if_def.data_valid, if_def.sequence_error, if_def.parity_error, if_def.length_error};
  assign pl[1] = {if_np.soc, if_np.eoc, if_np.data_valid, if_np.sequence_error, if_np.parity_error, if_np.length_error};
  assign pl[2] = {if_mx.soc, if_mx.eoc, if_mx.data_valid, if_mx.sequence_error, if_mx.parity_error, if_mx.length_error};
  assign dvw[0] = {if_def.data_bits, if_def.data};
  assign dvw[1] = {if_np.data_bits, if_np.data};
  assign dvw[2] = {if_mx.data_bits, if_mx.data};
  assign bcv[0] = if_def.byte_count;
  assign bcv[1] = if_np.byte_count;
  assign bcv[2] = {5'd0, if_mx.byte_count};
  assign lvl[0] = {if_def.crc_ok, if_def.short_frame};
  assign lvl[1] = {if_np.crc_ok, if_np.short_frame};
  assign lvl[2] = {if_mx.crc_ok, if_mx.short_frame};

  int          cnt   [3][6];
  int          ndv   [3];
  logic [10:0] dvlog [3][64];
  int          base  [3][6];
  int          base_dv [3];

  initial begin
    for (int d = 0; d < 3; d++) begin
      ndv[d] = 0;
      for (int k = 0; k < 6; k++) cnt[d][k] = 0;
    end
  end

  // Pulse counters and data_valid capture, sampled mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 6; k++) begin
        if (pl[d][k]) cnt[d][k] <= cnt[d][k] + 1;
      end
      if (pl[d][P_DV] && ndv[d] < 64) begin
        dvlog[d][ndv[d]] <= dvw[d];
        ndv[d] <= ndv[d] + 1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic mark();
    for (int d = 0; d < 3; d++) begin
      base_dv[d] = ndv[d];
      for (int k = 0; k < 6; k++) base[d][k] = cnt[d][k];
    end
  endtask

  task automatic chk_frame(input string tag, input int d, input int e_soc, input int e_eoc,
                           input int e_dv, input int e_seq, input int e_par, input int e_len,
                           input int e_bc, input int e_crc, input int e_short);
    chk($sformatf("%s.soc", tag),   cnt[d][P_SOC] - base[d][P_SOC], e_soc);
    chk($sformatf("%s.eoc", tag),   cnt[d][P_EOC] - base[d][P_EOC], e_eoc);
    chk($sformatf("%s.dv", tag),    cnt[d][P_DV]  - base[d][P_DV],  e_dv);
    chk($sformatf("%s.seqerr", tag), cnt[d][P_SEQ] - base[d][P_SEQ], e_seq);
    chk($sformatf("%s.parerr", tag), cnt[d][P_PAR] - base[d][P_PAR], e_par);
    chk($sformatf("%s.lenerr", tag), cnt[d][P_LEN] - base[d][P_LEN], e_len);
    chk($sformatf("%s.bytes", tag), int'(bcv[d]), e_bc);
    chk($sformatf("%s.crc_ok", tag), int'(lvl[d][1]), e_crc);
    chk($sformatf("%s.short", tag), int'(lvl[d][0]), e_short);
  endtask

  task automatic chk_dv(input string tag, input int d, input int idx, input int e_data, input int e_bits);
    logic [10:0] w;
    w = dvlog[d][base_dv[d] + idx];
    chk($sformatf("%s.data%0d", tag, idx), int'(w[7:0]), e_data);
    chk($sformatf("%s.bits%0d", tag, idx), int'(w[10:8]), e_bits);
  endtask

  task automatic sym(input pcd_bit_seq_t s);
    seq_s = s;
    vld_s = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    vld_s = 1'b0;
    seq_s = SEQ_Y;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if (b) sym(SEQ_X);
    else if (prev_one) sym(SEQ_Y);
    else sym(SEQ_Z);
    prev_one = b;
  endtask

  task automatic start_frame();
    sym(SEQ_Z);
    prev_one = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic inv);
    send_bits(v, 8);
    send_bit(~(^v) ^ inv);
  endtask

  task automatic end_frame();
    send_bit(1'b0);
    sym(SEQ_Y);
    idle(4);
  endtask

  initial begin
    idle(2);
    rst_n = 1'b1;
    idle(2);

    chk("rst.data",   int'(if_def.data), 0);
    chk("rst.bits",   int'(if_def.data_bits), 0);
    chk("rst.bytes",  int'(if_def.byte_count), 0);
    chk("rst.levels", int'({if_def.crc_ok, if_def.short_frame}), 0);
    chk("rst.pulses", int'(pl[0]), 0);

    // REQA short frame
    mark();
    start_frame(); send_bits(8'h26, 7); end_frame();
    chk_frame("reqa", D_DEF, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    chk_dv("reqa", D_DEF, 0, 8'h26, 7);

    // HLTA with valid CRC
    mark();
    start_frame();
    send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h57, 1'b0); send_byte(8'hCD, 1'b0);
    end_frame();
    chk_frame("hlta", D_DEF, 1, 1, 4, 0, 0, 0, 4, 1, 0);
    chk_dv("hlta", D_DEF, 0, 8'h50, 0);
    chk_dv("hlta", D_DEF, 1, 8'h00, 0);
    chk_dv("hlta", D_DEF, 2, 8'h57, 0);
    chk_dv("hlta", D_DEF, 3, 8'hCD, 0);
    chk_frame("hlta_np", D_NP, 1, 1, 4, 0, 0, 0, 4, 1, 0);

    // HLTA with corrupted CRC byte
    mark();
    start_frame();
    send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h57, 1'b0); send_byte(8'hCC, 1'b0);
    end_frame();
    chk_frame("badcrc", D_DEF, 1, 1, 4, 0, 0, 0, 4, 0, 0);
    chk_dv("badcrc", D_DEF, 3, 8'hCC, 0);

    // Inverted parity on the second byte
    mark();
    start_frame();
    send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b1); send_byte(8'h57, 1'b0); send_byte(8'hCD, 1'b0);
    end_frame();
    chk_frame("parinv", D_DEF, 1, 1, 1, 0, 1, 0, 1, 0, 0);
    chk_dv("parinv", D_DEF, 0, 8'h50, 0);
    chk_frame("parinv_np", D_NP, 1, 1, 4, 0, 0, 0, 4, 1, 0);
    chk_dv("parinv_np", D_NP, 1, 8'h00, 0);

    // Three bytes into the MAX_BYTES=2 variant
    mark();
    start_frame();
    send_byte(8'h50, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h57, 1'b0);
    end_frame();
    chk_frame("maxlen", D_MX, 1, 1, 2, 0, 0, 1, 2, 0, 0);
    chk_frame("maxlen_def", D_DEF, 1, 1, 3, 0, 0, 0, 3, 0, 0);

    // ERROR symbol mid-byte
    mark();
    start_frame();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sym(SEQ_ERROR); sym(SEQ_Z); sym(SEQ_Y);
    idle(4);
    chk_frame("seqerr", D_DEF, 1, 1, 0, 1, 0, 0, 0, 0, 0);

    // Empty Z Y frame
    mark();
    sym(SEQ_Z); sym(SEQ_Y); sym(SEQ_Y); sym(SEQ_Y);
    idle(4);
    chk_frame("zy", D_DEF, 1, 1, 0, 1, 0, 0, 0, 0, 0);

    // Reset after five bits, then a clean REQA
    mark();
    start_frame(); send_bits(8'h26, 5);
    vld_s = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    chk("abort.soc", cnt[D_DEF][P_SOC] - base[D_DEF][P_SOC], 1);
    chk("abort.eoc", cnt[D_DEF][P_EOC] - base[D_DEF][P_EOC], 0);
    chk("abort.dv",  cnt[D_DEF][P_DV]  - base[D_DEF][P_DV], 0);
    mark();
    start_frame(); send_bits(8'h26, 7); end_frame();
    chk_frame("reqa2", D_DEF, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    chk_dv("reqa2", D_DEF, 0, 8'h26, 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/frame_decode_ext.md
Name: frame_decode_ext

Overview:
Parametrised successor to the PCD frame decoder. It turns PCDBitSequence symbols from sequence_decode into SOC/EOC, data bytes and error flags, and adds:
- optional parity checking,
- a maximum frame length with byte counting,
- running CRC_A verification,
- short-frame (7-bit REQA/WUPA) detection.

It sits between sequence_decode and the ISO14443-3 framing/command layer, so that layer no longer needs its own CRC or length logic.

Parameters:
MAX_BYTES, 64, maximum accepted full bytes per frame (>=1)
PARITY_CHECK, 1, 1: compare odd parity bits; 0: consume parity bits without checking
CRC_CHECK, 1, 1: compute CRC_A and drive crc_ok; 0: crc_ok tied 0
BC_W, $clog2(MAX_BYTES+1), width of byte_count

Ports:
clk  in  1  13.56MHz recovered carrier clock; stops during pauses
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
sd_seq  in  PCDBitSequence  sequence from sequence_decode
sd_seq_valid  in  1  sd_seq qualifier
soc  out  1  start of comms pulse
eoc  out  1  end of comms pulse
data  out  8  received bits, LSB first; bit i = i-th bit of the byte
data_bits  out  3  valid bits in data; 0 = all 8
data_valid  out  1  data/data_bits valid pulse
byte_count  out  BC_W  full bytes accepted in the current frame; held after EOC
crc_ok  out  1  level, valid from eoc pulse until next soc
short_frame  out  1  level, valid from eoc pulse until next soc
sequence_error  out  1  pulse
parity_error  out  1  pulse
length_error  out  1  pulse

Behaviour:
- Reset values: all pulse outputs 0; data = 0; data_bits = 0; byte_count = 0; crc_ok = 0; short_frame = 0. Internal: idle = 1, last_seq = Y.
- State is only updated on clocks with sd_seq_valid = 1. All pulses last exactly one clock.
- Decoding uses last_seq (one-sequence delay): bit = (last_seq == X).
- IDLE:
  - last_seq == Z → soc, go RX.
  - On soc, clear: data_bits, byte_count, crc_ok, short_frame, error latch, parity-pending. Set expected_parity = 1 and crc = 0x6363.
  - Y in IDLE is ignored.
- RX, EOC check has top priority: sd_seq == Y with last_seq in {Y, Z} → eoc, go IDLE. In the same clock:
  - parity pending → parity_error;
  - no bits received (ZY frame) → sequence_error;
  - no error, no parity pending, data_bits != 0 → data_valid (partial byte);
  - short_frame = (no error, byte_count == 0, data_bits == 7);
  - crc_ok = CRC_CHECK, no error, data_bits == 0, byte_count >= 3, crc == 0x0000.
- RX, error latched → ignore everything until EOC.
- RX, last_seq == ERROR → sequence_error, latch error, clear parity-pending.
- RX, parity pending, check:
  - PARITY_CHECK = 1 and bit != expected_parity → parity_error, latch error.
  - Otherwise, if byte_count == MAX_BYTES → length_error, latch error, no data_valid.
  - Otherwise → data_valid with data_bits = 0; byte_count + 1; expected_parity = 1.
- RX, data bit:
  - data[data_bits] = bit; data_bits + 1 (wraps 7 → 0).
  - bit = 1 toggles expected_parity.
  - After the 8th bit, set parity pending.
  - CRC update per bit: fb = crc[0] ^ bit; crc = (crc >> 1) ^ (fb ? 0x8408 : 0).
  - data_valid is never asserted on data bits.
- Latency: data_valid is asserted on the clock after the sd_seq_valid whose sd_seq follows the parity symbol.
- byte_count never exceeds MAX_BYTES.
- crc_ok and short_frame are mutually exclusive.
- Reset mid-frame: no eoc is emitted; the block returns to IDLE.

Test Plan:
- REQA: Z, then bits of 0x26 LSB-first (7 bits), then Y Y → soc; eoc with data_valid, data = 0x26, data_bits = 7; short_frame = 1, crc_ok = 0, byte_count = 0, no errors.
- HLTA 0x50 0x00 0x57 0xCD with correct parity → 4 data_valid pulses, each data_bits = 0; eoc with byte_count = 4, crc_ok = 1. The same frame with last byte 0xCC → crc_ok = 0, no error pulse.
- Inverted parity on byte 2 → parity_error pulse at that byte, no further data_valid, eoc with no repeat parity_error. Repeat with PARITY_CHECK = 0 → no parity_error, all 4 bytes delivered.
- MAX_BYTES = 2, 3-byte frame → 2 data_valid pulses, then length_error on the 3rd parity; byte_count = 2; crc_ok = 0.
- ERROR symbol mid-byte → one sequence_error pulse, eoc still issued. Z Y frame → soc, then eoc + sequence_error.
- Reset asserted mid-frame after 5 bits, then a clean 0x26 short frame → no eoc for the aborted frame; the second frame decodes exactly as in the REQA case.
